// File: rtl/fir_out_quantizer_if.sv
// Sample stream bundle for fir_out_quantizer: the free-running filter side
// (valid_in/din) and the backpressured consumer side (dout/valid_out/ready_out).
interface fir_out_quantizer_if #(
    parameter int INPUT_WIDTH  = 26,
    parameter int OUTPUT_WIDTH = 16
);
    logic                    valid_in;
    logic [INPUT_WIDTH-1:0]  din;
    logic [OUTPUT_WIDTH-1:0] dout;
    logic                    valid_out;
    logic                    ready_out;

    // Environment side: produces filter samples, consumes conditioned words
    modport master (
        output valid_in, din, ready_out,
        input  dout, valid_out
    );

    // Quantizer side
    modport slave (
        input  valid_in, din, ready_out,
        output dout, valid_out
    );
endinterface

// File: rtl/fir_out_quantizer.sv
// Output conditioning for the systolic FIR: decimate, round/shift, saturate,
// then buffer in a first-word-fall-through FIFO so a stalling consumer never
// stalls the filter. Sticky flags report clamping and FIFO drops.
module fir_out_quantizer #(
    parameter int INPUT_WIDTH  = 26,
    parameter int OUTPUT_WIDTH = 16,
    parameter int SHIFT        = 10,
    parameter int ROUND_MODE   = 1,
    parameter int DECIM        = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    fir_out_quantizer_if.slave      bus,
    input  logic                    clr_flags,
    output logic                    sat_flag,
    output logic                    ovf_flag
);
    localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    // Significant bits left after the shift (incl. the guard bit)
    localparam int SW     = INPUT_WIDTH + 1 - SHIFT;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [INPUT_WIDTH:0] RND_C =
        (ROUND_MODE == 1 && SHIFT > 0) ? ((INPUT_WIDTH+1)'(1) <<< RND_SH) : '0;

    logic [PH_W-1:0]                phase;
    logic                           accept;
    logic signed [INPUT_WIDTH:0]    din_ext;
    logic signed [INPUT_WIDTH:0]    s1_data;
    logic [1:0]                     vld_pipe;
    logic [OUTPUT_WIDTH-1:0]        clamp_val;
    logic                           clamp_sat;
    logic [OUTPUT_WIDTH-1:0]        s2_data;

    logic [OUTPUT_WIDTH-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]                  wr_ptr;
    logic [AW-1:0]                  rd_ptr;
    logic [AW:0]                    count;
    logic                           fifo_ne;
    logic                           full;
    logic                           pop;
    logic                           push;
    logic                           drop;
    logic                           sat_ev;

    // Phase 0 keeps the sample, so the first sample after reset is accepted
    assign accept = bus.valid_in && (phase == '0);

    // Decimation phase advances on every filter sample, kept or not
    always_ff @(posedge clk) begin
        if (rst)
            phase <= '0;
        else if (bus.valid_in)
            phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
    end

    // One guard bit above the input so rounding the max positive value cannot wrap
    assign din_ext = {bus.din[INPUT_WIDTH-1], bus.din};

    // Stage 1: round-half-up bias (or none) then arithmetic shift
    always_ff @(posedge clk) begin
        s1_data <= (din_ext + RND_C) >>> SHIFT;
    end

    // Valid shift register for the two pipeline stages
    always_ff @(posedge clk) begin
        if (rst)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[0], accept};
    end

    generate
        if (SW <= OUTPUT_WIDTH) begin : g_nosat
            // Result always fits: plain sign extension
            assign clamp_val = OUTPUT_WIDTH'(s1_data);
            assign clamp_sat = 1'b0;
        end else begin : g_sat
            localparam logic signed [INPUT_WIDTH:0] MAXV =
                {{(INPUT_WIDTH+2-OUTPUT_WIDTH){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
            localparam logic signed [INPUT_WIDTH:0] MINV =
                {{(INPUT_WIDTH+2-OUTPUT_WIDTH){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};
            // Clamp the shifted value to the signed output range
            always_comb begin
                clamp_val = s1_data[OUTPUT_WIDTH-1:0];
                clamp_sat = 1'b0;
                if (s1_data > MAXV) begin
                    clamp_val = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
                    clamp_sat = 1'b1;
                end else if (s1_data < MINV) begin
                    clamp_val = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
                    clamp_sat = 1'b1;
                end
            end
        end
    endgenerate

    // Stage 2: register the clamped word
    always_ff @(posedge clk) begin
        s2_data <= clamp_val;
    end

    assign sat_ev  = vld_pipe[0] && clamp_sat;
    assign fifo_ne = (count != '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign pop     = fifo_ne && bus.ready_out;
    // A pop frees the slot in the same edge, so a full FIFO still takes the write
    assign push    = vld_pipe[1] && (!full || pop);
    assign drop    = vld_pipe[1] && full && !pop;

    // FIFO storage; no reset needed since dout is masked while empty
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s2_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky flags; an event beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            if (sat_ev)
                sat_flag <= 1'b1;
            else if (clr_flags)
                sat_flag <= 1'b0;
            if (drop)
                ovf_flag <= 1'b1;
            else if (clr_flags)
                ovf_flag <= 1'b0;
        end
    end

    assign bus.valid_out = fifo_ne;
    assign bus.dout      = fifo_ne ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fir_out_quantizer.sv
// Bench for fir_out_quantizer: directed vectors on three parameterisations
// sharing one stimulus, plus a queue-based reference model of the default
// (round, DECIM=1) instance checked every cycle.
module tb_fir_out_quantizer;
    localparam int IW    = 26;
    localparam int OW    = 16;
    localparam int SH    = 10;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [IW-1:0] din;
    logic          ready_out;
    logic          clr_flags;
    logic          sat_r, ovf_r, sat_t, ovf_t, sat_d, ovf_d;
    bit            chk_en;
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    fir_out_quantizer_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) if_r ();
    fir_out_quantizer_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) if_t ();
    fir_out_quantizer_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) if_d ();

    assign if_r.valid_in = valid_in;  assign if_r.din = din;  assign if_r.ready_out = ready_out;
    assign if_t.valid_in = valid_in;  assign if_t.din = din;  assign if_t.ready_out = ready_out;
    assign if_d.valid_in = valid_in;  assign if_d.din = din;  assign if_d.ready_out = ready_out;

    fir_out_quantizer #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .SHIFT(SH), .ROUND_MODE(1),
                        .DECIM(1), .FIFO_DEPTH(DEPTH)) u_rnd (
        .clk(clk), .rst(rst), .bus(if_r), .clr_flags(clr_flags), .sat_flag(sat_r), .ovf_flag(ovf_r));
    fir_out_quantizer #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .SHIFT(SH), .ROUND_MODE(0),
                        .DECIM(1), .FIFO_DEPTH(DEPTH)) u_trn (
        .clk(clk), .rst(rst), .bus(if_t), .clr_flags(clr_flags), .sat_flag(sat_t), .ovf_flag(ovf_t));
    fir_out_quantizer #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .SHIFT(SH), .ROUND_MODE(1),
                        .DECIM(2), .FIFO_DEPTH(DEPTH)) u_dec (
        .clk(clk), .rst(rst), .bus(if_d), .clr_flags(clr_flags), .sat_flag(sat_d), .ovf_flag(ovf_d));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural value: floor((din + bias) / 2^SH), then clamp to OW bits
    function automatic void quant(input logic [IW-1:0] d, input bit rnd,
                                  output logic [OW-1:0] v, output bit s);
        longint x, q, dv, mx, mn;
        dv = longint'(1) << SH;
        mx = (longint'(1) << (OW-1)) - 1;
        mn = -(longint'(1) << (OW-1));
        x  = longint'($signed(d));
        if (rnd) x = x + (dv / 2);
        if (x >= 0) q = x / dv;
        else        q = -((-x + dv - 1) / dv);
        s = 1'b0;
        if (q > mx) begin q = mx; s = 1'b1; end
        if (q < mn) begin q = mn; s = 1'b1; end
        v = q[OW-1:0];
    endfunction

    // Reference model for u_rnd: samples carry the edge at which they flag and land
    typedef struct {
        int            wr_edge;
        int            sat_edge;
        logic [OW-1:0] val;
        bit            sat;
    } pend_t;

    pend_t         pq[$];
    logic [OW-1:0] fq[$];
    bit            m_sat, m_ovf;
    int            edge_no = 0;

    always @(posedge clk) begin : mdl
        bit            pop_m, sat_ev_m, wr_m, drop_m, s;
        logic [OW-1:0] wv, v;
        pend_t         p;
        if (rst) begin
            pq.delete();
            fq.delete();
            m_sat = 1'b0;
            m_ovf = 1'b0;
        end else begin
            pop_m    = (fq.size() > 0) && ready_out;
            sat_ev_m = 1'b0;
            wr_m     = 1'b0;
            drop_m   = 1'b0;
            wv       = '0;
            foreach (pq[i])
                if (pq[i].sat_edge == edge_no && pq[i].sat) sat_ev_m = 1'b1;
            if (pq.size() > 0 && pq[0].wr_edge == edge_no) begin
                wr_m = 1'b1;
                wv   = pq[0].val;
                void'(pq.pop_front());
            end
            if (pop_m) void'(fq.pop_front());
            if (wr_m) begin
                if (fq.size() < DEPTH) fq.push_back(wv);
                else                   drop_m = 1'b1;
            end
            m_sat = sat_ev_m ? 1'b1 : (clr_flags ? 1'b0 : m_sat);
            m_ovf = drop_m   ? 1'b1 : (clr_flags ? 1'b0 : m_ovf);
            if (valid_in) begin
                quant(din, 1'b1, v, s);
                p.wr_edge  = edge_no + 2;
                p.sat_edge = edge_no + 1;
                p.val      = v;
                p.sat      = s;
                pq.push_back(p);
            end
        end
        edge_no++;
    end

    // Compare u_rnd against the model mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_valid", 32'(if_r.valid_out), 32'(fq.size() > 0));
            check("mdl_dout",  32'(if_r.dout), (fq.size() > 0) ? 32'(fq[0]) : 32'd0);
            check("mdl_sat",   32'(sat_r), 32'(m_sat));
            check("mdl_ovf",   32'(ovf_r), 32'(m_ovf));
        end
    end

    typedef struct {
        logic [IW-1:0] din;
        logic [OW-1:0] rnd;
        logic [OW-1:0] trn;
    } vec_t;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid_in = 1'b0; clr_flags = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vec_t          tbl[7];
        logic [OW-1:0] got[$];

        tbl[0] = '{26'd1536,           16'h0002, 16'h0001};
        tbl[1] = '{26'h3FFFE00,        16'h0000, 16'hFFFF};  // -512
        tbl[2] = '{26'h3FFFDFF,        16'hFFFF, 16'hFFFF};  // -513
        tbl[3] = '{26'd1535,           16'h0001, 16'h0001};
        tbl[4] = '{26'h3FFFFFF,        16'h0000, 16'hFFFF};  // -1
        tbl[5] = '{26'h1FFFFFF,        16'h7FFF, 16'h7FFF};
        tbl[6] = '{26'h2000000,        16'h8000, 16'h8000};

        rst = 1'b1; valid_in = 1'b0; din = '0; ready_out = 1'b1; clr_flags = 1'b0; chk_en = 1'b0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        check("rst_dout",  32'(if_r.dout), 32'd0);
        check("rst_valid", 32'(if_r.valid_out), 32'd0);
        check("rst_sat",   32'(sat_r), 32'd0);
        check("rst_ovf",   32'(ovf_r), 32'd0);
        check("rst_dec_valid", 32'(if_d.valid_out), 32'd0);
        rst = 1'b0;

        // Rounding / truncation / saturation vectors, latency 3
        for (int i = 0; i < 7; i++) begin
            valid_in = 1'b1; din = tbl[i].din;
            @(negedge clk);
            valid_in = 1'b0;
            @(negedge clk);
            check("lat_not_early", 32'(if_r.valid_out), 32'd0);
            @(negedge clk);
            check("lat3_valid", 32'(if_r.valid_out), 32'd1);
            check("vec_round",  32'(if_r.dout), 32'(tbl[i].rnd));
            check("vec_trunc",  32'(if_t.dout), 32'(tbl[i].trn));
        end
        check("sat_sticky", 32'(sat_r), 32'd1);

        // clr alone clears; clr coinciding with a saturation event leaves it set
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("clr_sat", 32'(sat_r), 32'd0);
        valid_in = 1'b1; din = 26'h1FFFFFF;
        @(negedge clk);
        valid_in = 1'b0; clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("clr_vs_event", 32'(sat_r), 32'd1);
        repeat (3) @(negedge clk);

        // Decimation by 2 keeps samples 1, 3, 5
        do_reset();
        got.delete();
        for (int c = 0; c < 14; c++) begin
            if (if_d.valid_out) got.push_back(if_d.dout);
            valid_in = (c < 6);
            din      = 26'(1024 * (c + 1));
            @(negedge clk);
        end
        valid_in = 1'b0;
        check("dec_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            check("dec_value", 32'(got[i]), 32'(2 * i + 1));

        // Backpressure: FIFO keeps 1..4, drops 5 and 6
        do_reset();
        ready_out = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            valid_in = 1'b1; din = 26'(1024 * k);
            @(negedge clk);
        end
        valid_in = 1'b0;
        repeat (4) @(negedge clk);
        check("bp_ovf", 32'(ovf_r), 32'd1);
        ready_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_drain_valid", 32'(if_r.valid_out), 32'd1);
            check("bp_drain_dout",  32'(if_r.dout), 32'(i + 1));
            @(negedge clk);
        end
        check("bp_empty", 32'(if_r.valid_out), 32'd0);

        // Full FIFO with pop and write on the same edge: nothing dropped
        ready_out = 1'b0; clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        for (int k = 10; k <= 13; k++) begin
            valid_in = 1'b1; din = 26'(1024 * k);
            @(negedge clk);
        end
        valid_in = 1'b0;
        repeat (3) @(negedge clk);
        valid_in = 1'b1; din = 26'(1024 * 14);
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        ready_out = 1'b1;
        @(negedge clk);
        ready_out = 1'b0;
        check("fullpw_ovf",  32'(ovf_r), 32'd0);
        check("fullpw_head", 32'(if_r.dout), 32'd11);
        ready_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("fullpw_drain", 32'(if_r.dout), 32'(11 + i));
            @(negedge clk);
        end
        check("fullpw_empty", 32'(if_r.valid_out), 32'd0);

        // Reset with 3 words buffered and 2 in flight
        do_reset();
        ready_out = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            valid_in = 1'b1; din = (k == 1) ? 26'h1FFFFFF : 26'(1024 * k);
            @(negedge clk);
        end
        valid_in = 1'b0;
        check("pre_rst_sat",   32'(sat_r), 32'd1);
        check("pre_rst_valid", 32'(if_r.valid_out), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_dout",  32'(if_r.dout), 32'd0);
        check("rst_mid_valid", 32'(if_r.valid_out), 32'd0);
        check("rst_mid_sat",   32'(sat_r), 32'd0);
        check("rst_mid_ovf",   32'(ovf_r), 32'd0);
        rst = 1'b0;
        valid_in = 1'b1; din = 26'(1024 * 7);
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        check("post_rst_early", 32'(if_r.valid_out), 32'd0);
        @(negedge clk);
        check("post_rst_valid",  32'(if_r.valid_out), 32'd1);
        check("post_rst_dout",   32'(if_r.dout), 32'd7);
        check("post_rst_phase",  32'(if_d.valid_out), 32'd1);
        check("post_rst_dec",    32'(if_d.dout), 32'd7);
        ready_out = 1'b1;

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            valid_in  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       din = 26'($urandom);
                1:       din = 26'($urandom_range(0, 8191)) - 26'd4096;
                2:       din = 26'h1FFFC00 + 26'($urandom_range(0, 2047));
                default: din = 26'h2000000 + 26'($urandom_range(0, 2047)) - 26'd1024;
            endcase
            ready_out = ((c / 200) % 3 == 2) ? ($urandom_range(0, 7) == 0)
                                             : ($urandom_range(0, 3) != 0);
            clr_flags = ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        valid_in = 1'b0; clr_flags = 1'b0; ready_out = 1'b1;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
